atm_account_responder: RTL and testbench
========================================

// Module: atm_account_responder
// PURPOSE
//  Bank-side responder for the ATM controller. Receives one request per valid/ready handshake:
//  find card, auth PIN, balance, withdraw, deposit or wire. Searches the account table serially,
//  one entry per cycle, updates balance, PIN-lockout and session state, and returns one response.
//  Sits between the ATM controller FSM and the account storage.
// PARAMETERS
//  NUM_ACCTS      20  accounts in table (index width IDX_W = $clog2(NUM_ACCTS))
//  CARD_W         12  card/account number width
//  PIN_W          8   PIN width
//  BAL_W          16  balance width, unsigned
//  AMT_W          10  transaction amount width, unsigned
//  MAX_PIN_TRIES  3   consecutive bad PINs before the account locks
// PORTS
//  clk           in   1       clock
//  reset         in   1       synchronous, active-high
//  req_valid     in   1       request present
//  req_ready     out  1       responder can accept; high only in IDLE
//  req_op        in   3       0 FIND_CARD, 1 AUTH_PIN, 2 BALANCE, 3 WITHDRAW, 4 DEPOSIT, 5 WIRE
//  req_card      in   CARD_W  source card number
//  req_pin       in   PIN_W   PIN (AUTH_PIN only)
//  req_amount    in   AMT_W   amount (WITHDRAW/DEPOSIT/WIRE)
//  req_dest      in   CARD_W  destination account (WIRE only)
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       controller takes response
//  rsp_status    out  3       0 OK, 1 NO_CARD, 2 BAD_PIN, 3 LOCKED, 4 INSUFFICIENT, 5 NO_DEST, 6 BAD_OP, 7 NOT_AUTH
//  rsp_balance   out  BAL_W   source balance after the operation; 0 when status is NO_CARD/BAD_OP
//  rsp_is_credit out  1       credit flag of the matched account; 0 when not found
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_status=0; rsp_balance=0; rsp_is_credit=0.
//   Session is cleared, lockout counters are zeroed, and balances reload from the package init table.
//   Reset mid-operation drops the in-flight request with no table write.
//  FSM: IDLE -> SEARCH -> [SEARCH_DEST, WIRE only] -> EXEC -> RESP -> IDLE.
//   IDLE: the accept edge is the edge where req_valid & req_ready. All req_* fields latch on it.
//   SEARCH: compares entry idx to the latched card, idx = 0..NUM_ACCTS-1, one entry per cycle.
//    The lowest matching index wins. On a match, or a miss at the last index, go to EXEC (or SEARCH_DEST).
//   SEARCH_DEST: same scan for req_dest. A miss, or dest index == source index, gives NO_DEST.
//   EXEC: single cycle that evaluates the op and performs at most one table write per account.
//   RESP: rsp_* are registered and held stable while rsp_valid & !rsp_ready.
//    Go to IDLE on the edge where rsp_ready is high. The next request is accepted no earlier than the edge after that.
//  Latency: a source match at index k gives rsp_valid k+3 edges after accept.
//   A source miss gives NUM_ACCTS+2. WIRE adds j+1 edges for a dest match at j (NUM_ACCTS on a miss).
//  Op rules (checked in this order: BAD_OP, NO_CARD, then the op):
//   req_op > 5: BAD_OP. No search; go straight to EXEC, so latency is 2.
//   FIND_CARD: OK if found. Always clears the session.
//   AUTH_PIN: if lock_cnt == MAX_PIN_TRIES: LOCKED.
//    Else, PIN match: OK, lock_cnt := 0, session := {valid, idx}.
//    Else: BAD_PIN, lock_cnt++. The attempt that reaches MAX_PIN_TRIES returns LOCKED. Session cleared.
//   BALANCE/WITHDRAW/DEPOSIT/WIRE: NOT_AUTH unless session valid and session idx == matched idx.
//   WITHDRAW: amount > balance gives INSUFFICIENT (no write). Else balance -= amount.
//   DEPOSIT: balance := min(balance + amount, 2^BAL_W-1), saturating. Status OK.
//   WIRE: NO_DEST or INSUFFICIENT gives no write.
//    Else src -= amount and dest := saturating add, both in the same EXEC edge.
//  Credit accounts follow the same arithmetic; the balance is available credit.
//  A lock persists until reset. A correct PIN on a locked account still returns LOCKED.
// STRUCTURE
//  Shared package atm_pkg: op and status codes, FSM state encodings, and the init table.
//   Init table: card, PIN, credit flag, initial balance per entry.
//   Entry 0 = 1281 / 8'hCD / debit / 500. Entry 1 = 3698 / 8'hDB / credit / 1200.
//   Card 2133 = entry 2. Card 1146 = entry 3 / balance 65500.
//  Sub-module atm_account_table: balance and lock_cnt registers with reset reload.
//   One combinational read port by index and two write ports (src, dest) for WIRE.
//  The responder holds only the FSM, scan counter, latched request, session and response registers.
// TESTING
//  1. FIND_CARD 1281 -> rsp_valid 3 edges after accept; OK, is_credit 0, balance 500.
//  2. AUTH_PIN 1281 with 8'h00 three times -> BAD_PIN, BAD_PIN, LOCKED.
//     Then AUTH_PIN with 8'hCD -> LOCKED. After reset, AUTH_PIN 8'hCD -> OK.
//  3. Auth 1281, WITHDRAW 600 -> INSUFFICIENT, balance 500.
//     Then WITHDRAW 200 -> OK, 300. Then BALANCE -> 300.
//  4. Auth 1146, DEPOSIT 100 -> OK, balance 65535 (saturated).
//     WITHDRAW on 2133 without auth -> NOT_AUTH.
//  5. Auth 1281, WIRE 100 to 3698 -> OK, balance 400. Auth 3698, BALANCE -> 1300.
//     WIRE to 4000 -> NO_DEST. WIRE to 1281 from 1281 -> NO_DEST.
//  6. FIND_CARD 4000 -> NO_CARD after NUM_ACCTS+2 edges.
//     Hold rsp_ready low 5 cycles -> rsp stable, req_ready 0. Assert reset mid-SEARCH -> IDLE, rsp_valid 0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account responder.
// Holds the table geometry, the op/status/FSM encodings, the power-on account table
// and a saturating balance add shared by the deposit and wire paths.
package atm_pkg;

    localparam int unsigned NUM_ACCTS     = 20;
    localparam int unsigned CARD_W        = 12;
    localparam int unsigned PIN_W         = 8;
    localparam int unsigned BAL_W         = 16;
    localparam int unsigned AMT_W         = 10;
    localparam int unsigned MAX_PIN_TRIES = 3;
    localparam int unsigned IDX_W         = $clog2(NUM_ACCTS);
    localparam int unsigned LOCK_W        = $clog2(MAX_PIN_TRIES + 1);

    localparam logic [2:0] OP_MAX = 3'd5;

    typedef enum logic [2:0] {
        OpFindCard = 3'd0,
        OpAuthPin  = 3'd1,
        OpBalance  = 3'd2,
        OpWithdraw = 3'd3,
        OpDeposit  = 3'd4,
        OpWire     = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        StatOk           = 3'd0,
        StatNoCard       = 3'd1,
        StatBadPin       = 3'd2,
        StatLocked       = 3'd3,
        StatInsufficient = 3'd4,
        StatNoDest       = 3'd5,
        StatBadOp        = 3'd6,
        StatNotAuth      = 3'd7
    } status_e;

    typedef enum logic [2:0] {
        StIdle,
        StSearch,
        StSearchDest,
        StExec,
        StResp
    } state_e;

    typedef struct packed {
        logic [CARD_W-1:0] card;
        logic [PIN_W-1:0]  pin;
        logic              credit;
        logic [BAL_W-1:0]  bal;
    } acct_init_t;

    // Power-on contents of one table entry. Entries 0..3 are the well-known test
    // accounts; the remainder are filler with distinct card numbers.
    function automatic acct_init_t init_entry(input int unsigned idx);
        acct_init_t e;
        case (idx)
            0: begin
                e.card = CARD_W'(1281); e.pin = 8'hCD; e.credit = 1'b0; e.bal = BAL_W'(500);
            end
            1: begin
                e.card = CARD_W'(3698); e.pin = 8'hDB; e.credit = 1'b1; e.bal = BAL_W'(1200);
            end
            2: begin
                e.card = CARD_W'(2133); e.pin = 8'h33; e.credit = 1'b0; e.bal = BAL_W'(750);
            end
            3: begin
                e.card = CARD_W'(1146); e.pin = 8'h46; e.credit = 1'b0; e.bal = BAL_W'(65500);
            end
            default: begin
                e.card   = CARD_W'(2200 + 11 * idx);
                e.pin    = PIN_W'(13 * idx + 5);
                e.credit = idx[0];
                e.bal    = BAL_W'(100 * idx);
            end
        endcase
        return e;
    endfunction

    function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] bal,
                                                 input logic [AMT_W-1:0] amt);
        logic [BAL_W:0] sum;
        sum = {1'b0, bal} + (BAL_W+1)'(amt);
        return sum[BAL_W] ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
    endfunction

endpackage

// File: rtl/atm_account_responder_if.sv
// Request/response handshake between the ATM controller (master) and the
// account responder (slave).
//  req_valid/req_ready  request handshake; req_op/card/pin/amount/dest payload
//  rsp_valid/rsp_ready  response handshake; rsp_status/balance/is_credit payload
interface atm_account_responder_if;
    import atm_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [CARD_W-1:0] req_card;
    logic [PIN_W-1:0]  req_pin;
    logic [AMT_W-1:0]  req_amount;
    logic [CARD_W-1:0] req_dest;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_status;
    logic [BAL_W-1:0]  rsp_balance;
    logic              rsp_is_credit;

    modport master (
        output req_valid, req_op, req_card, req_pin, req_amount, req_dest, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance, rsp_is_credit
    );

    modport slave (
        input  req_valid, req_op, req_card, req_pin, req_amount, req_dest, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance, rsp_is_credit
    );

endinterface

// File: rtl/atm_account_table.sv
// Account storage: per-entry balance and PIN-lockout counter, reloaded on reset.
// Card, PIN and credit flag are fixed and come straight from the init table.
//  clk, reset      clock, synchronous active-high reset
//  rd_idx / rd_*   combinational read port
//  src_*           source balance write (absolute value)
//  dst_*           destination credit (saturating add of dst_amt)
//  lock_*          lockout counter write
module atm_account_table
    import atm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CARD_W-1:0] rd_card,
    output logic [PIN_W-1:0]  rd_pin,
    output logic              rd_credit,
    output logic [BAL_W-1:0]  rd_bal,
    output logic [LOCK_W-1:0] rd_lock,
    input  logic              src_we,
    input  logic [IDX_W-1:0]  src_idx,
    input  logic [BAL_W-1:0]  src_bal,
    input  logic              dst_we,
    input  logic [IDX_W-1:0]  dst_idx,
    input  logic [AMT_W-1:0]  dst_amt,
    input  logic              lock_we,
    input  logic [IDX_W-1:0]  lock_idx,
    input  logic [LOCK_W-1:0] lock_val
);

    logic [BAL_W-1:0]  bal_q  [NUM_ACCTS];
    logic [LOCK_W-1:0] lock_q [NUM_ACCTS];
    acct_init_t        rd_init;

    always_comb begin
        rd_init   = init_entry(int'(rd_idx));
        rd_card   = rd_init.card;
        rd_pin    = rd_init.pin;
        rd_credit = rd_init.credit;
        rd_bal    = bal_q[rd_idx];
        rd_lock   = lock_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                bal_q[i]  <= init_entry(i).bal;
                lock_q[i] <= '0;
            end
        end else begin
            if (src_we) bal_q[src_idx] <= src_bal;
            // src and dst never alias: a wire to itself is rejected upstream
            if (dst_we) bal_q[dst_idx] <= sat_add(bal_q[dst_idx], dst_amt);
            if (lock_we) lock_q[lock_idx] <= lock_val;
        end
    end

endmodule

// File: rtl/atm_account_responder.sv
// Bank-side responder for the ATM controller. Accepts one request, scans the
// account table one entry per cycle (source, then destination for wires),
// executes the op in a single cycle and holds a registered response until taken.
//  clk, reset  clock, synchronous active-high reset
//  bus         slave side of the request/response handshake
module atm_account_responder
    import atm_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    atm_account_responder_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCTS - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  scan_idx_q, src_idx_q, dest_idx_q, sess_idx_q;
    logic              src_found_q, dest_found_q, sess_valid_q;
    logic [2:0]        op_q;
    logic [CARD_W-1:0] card_q, dest_q;
    logic [PIN_W-1:0]  pin_q;
    logic [AMT_W-1:0]  amount_q;
    logic              req_ready_q, rsp_valid_q, rsp_is_credit_q;
    logic [2:0]        rsp_status_q;
    logic [BAL_W-1:0]  rsp_balance_q;

    logic [IDX_W-1:0]  rd_idx;
    logic [CARD_W-1:0] rd_card;
    logic [PIN_W-1:0]  rd_pin;
    logic              rd_credit;
    logic [BAL_W-1:0]  rd_bal;
    logic [LOCK_W-1:0] rd_lock;

    status_e           ex_status;
    logic [BAL_W-1:0]  ex_bal;
    logic              ex_credit, ex_src_we, ex_dst_we, ex_lock_we, sess_set, sess_clr;
    logic [LOCK_W-1:0] ex_lock_val;
    logic              exec;

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_status    = rsp_status_q;
    assign bus.rsp_balance   = rsp_balance_q;
    assign bus.rsp_is_credit = rsp_is_credit_q;

    // The read port follows the scan while searching and the source entry in EXEC.
    assign rd_idx = (state_q == StExec) ? src_idx_q : scan_idx_q;
    assign exec   = (state_q == StExec);

    atm_account_table u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_card  (rd_card),
        .rd_pin   (rd_pin),
        .rd_credit(rd_credit),
        .rd_bal   (rd_bal),
        .rd_lock  (rd_lock),
        .src_we   (ex_src_we & exec),
        .src_idx  (src_idx_q),
        .src_bal  (ex_bal),
        .dst_we   (ex_dst_we & exec),
        .dst_idx  (dest_idx_q),
        .dst_amt  (amount_q),
        .lock_we  (ex_lock_we & exec),
        .lock_idx (src_idx_q),
        .lock_val (ex_lock_val)
    );

    always_comb begin
        ex_status   = StatOk;
        ex_bal      = rd_bal;
        ex_credit   = rd_credit;
        ex_src_we   = 1'b0;
        ex_dst_we   = 1'b0;
        ex_lock_we  = 1'b0;
        ex_lock_val = rd_lock;
        sess_set    = 1'b0;
        sess_clr    = 1'b0;
        if (op_q > OP_MAX) begin
            ex_status = StatBadOp;
            ex_bal    = '0;
            ex_credit = 1'b0;
        end else if (!src_found_q) begin
            ex_status = StatNoCard;
            ex_bal    = '0;
            ex_credit = 1'b0;
            sess_clr  = (op_q == OpFindCard) || (op_q == OpAuthPin);
        end else if (op_q == OpFindCard) begin
            sess_clr = 1'b1;
        end else if (op_q == OpAuthPin) begin
            if (rd_lock == LOCK_W'(MAX_PIN_TRIES)) begin
                ex_status = StatLocked;
                sess_clr  = 1'b1;
            end else if (pin_q == rd_pin) begin
                ex_lock_we  = 1'b1;
                ex_lock_val = '0;
                sess_set    = 1'b1;
            end else begin
                ex_lock_we  = 1'b1;
                ex_lock_val = rd_lock + 1'b1;
                ex_status   = (ex_lock_val == LOCK_W'(MAX_PIN_TRIES)) ? StatLocked : StatBadPin;
                sess_clr    = 1'b1;
            end
        end else if (!(sess_valid_q && (sess_idx_q == src_idx_q))) begin
            ex_status = StatNotAuth;
        end else begin
            case (op_q)
                OpWithdraw: begin
                    if (BAL_W'(amount_q) > rd_bal) begin
                        ex_status = StatInsufficient;
                    end else begin
                        ex_src_we = 1'b1;
                        ex_bal    = rd_bal - BAL_W'(amount_q);
                    end
                end
                OpDeposit: begin
                    ex_src_we = 1'b1;
                    ex_bal    = sat_add(rd_bal, amount_q);
                end
                OpWire: begin
                    if (!dest_found_q || (dest_idx_q == src_idx_q)) begin
                        ex_status = StatNoDest;
                    end else if (BAL_W'(amount_q) > rd_bal) begin
                        ex_status = StatInsufficient;
                    end else begin
                        ex_src_we = 1'b1;
                        ex_dst_we = 1'b1;
                        ex_bal    = rd_bal - BAL_W'(amount_q);
                    end
                end
                default: ;  // balance enquiry: report as-is
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            scan_idx_q      <= '0;
            src_idx_q       <= '0;
            dest_idx_q      <= '0;
            src_found_q     <= 1'b0;
            dest_found_q    <= 1'b0;
            sess_valid_q    <= 1'b0;
            sess_idx_q      <= '0;
            op_q            <= '0;
            card_q          <= '0;
            dest_q          <= '0;
            pin_q           <= '0;
            amount_q        <= '0;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_status_q    <= '0;
            rsp_balance_q   <= '0;
            rsp_is_credit_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid && req_ready_q) begin
                        op_q         <= bus.req_op;
                        card_q       <= bus.req_card;
                        pin_q        <= bus.req_pin;
                        amount_q     <= bus.req_amount;
                        dest_q       <= bus.req_dest;
                        scan_idx_q   <= '0;
                        src_found_q  <= 1'b0;
                        dest_found_q <= 1'b0;
                        req_ready_q  <= 1'b0;
                        state_q      <= (bus.req_op > OP_MAX) ? StExec : StSearch;
                    end
                end
                StSearch: begin
                    if (rd_card == card_q || scan_idx_q == LAST_IDX) begin
                        src_found_q <= (rd_card == card_q);
                        src_idx_q   <= scan_idx_q;
                        scan_idx_q  <= '0;
                        state_q     <= (op_q == OpWire) ? StSearchDest : StExec;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                StSearchDest: begin
                    if (rd_card == dest_q || scan_idx_q == LAST_IDX) begin
                        dest_found_q <= (rd_card == dest_q);
                        dest_idx_q   <= scan_idx_q;
                        state_q      <= StExec;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                StExec: begin
                    rsp_valid_q     <= 1'b1;
                    rsp_status_q    <= ex_status;
                    rsp_balance_q   <= ex_bal;
                    rsp_is_credit_q <= ex_credit;
                    if (sess_set) begin
                        sess_valid_q <= 1'b1;
                        sess_idx_q   <= src_idx_q;
                    end else if (sess_clr) begin
                        sess_valid_q <= 1'b0;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_account_responder.sv
// Self-checking bench for atm_account_responder: directed scenarios followed by
// randomized traffic, all checked against a behavioural account model.
module tb_atm_account_responder;

    logic clk = 1'b0;
    logic reset;

    atm_account_responder_if bus ();

    atm_account_responder dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural account model
    int m_card[20], m_pin[20], m_credit[20], m_bal[20], m_lock[20];
    bit m_sess_v;
    int m_sess_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 20; i++) begin
            m_card[i]   = 2200 + 11 * i;
            m_pin[i]    = (13 * i + 5) % 256;
            m_credit[i] = i % 2;
            m_bal[i]    = 100 * i;
            m_lock[i]   = 0;
        end
        m_card[0] = 1281; m_pin[0] = 'hCD; m_credit[0] = 0; m_bal[0] = 500;
        m_card[1] = 3698; m_pin[1] = 'hDB; m_credit[1] = 1; m_bal[1] = 1200;
        m_card[2] = 2133; m_pin[2] = 'h33; m_credit[2] = 0; m_bal[2] = 750;
        m_card[3] = 1146; m_pin[3] = 'h46; m_credit[3] = 0; m_bal[3] = 65500;
        m_sess_v   = 0;
        m_sess_idx = 0;
    endfunction

    function automatic int find(input int card);
        for (int i = 0; i < 20; i++) if (m_card[i] == card) return i;
        return -1;
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_txn(input int op, input int card, input int pin, input int amt,
                             input int dest, output int st, output int bal, output int cr,
                             output int lat);
        int s, d;
        s = find(card);
        d = -1;
        st = 0; bal = 0; cr = 0;
        if (op > 5) begin
            st = 6; lat = 2;
            return;
        end
        lat = (s < 0) ? 22 : s + 3;
        if (op == 5) begin
            d = find(dest);
            lat += (d < 0) ? 20 : d + 1;
        end
        if (s < 0) begin
            st = 1;
            if (op <= 1) m_sess_v = 0;
            return;
        end
        cr = m_credit[s];
        if (op == 0) begin
            m_sess_v = 0;
        end else if (op == 1) begin
            if (m_lock[s] == 3) begin
                st = 3; m_sess_v = 0;
            end else if (pin == m_pin[s]) begin
                m_lock[s] = 0; m_sess_v = 1; m_sess_idx = s;
            end else begin
                m_lock[s]++;
                st = (m_lock[s] == 3) ? 3 : 2;
                m_sess_v = 0;
            end
        end else if (!(m_sess_v && m_sess_idx == s)) begin
            st = 7;
        end else if (op == 3) begin
            if (amt > m_bal[s]) st = 4;
            else m_bal[s] -= amt;
        end else if (op == 4) begin
            m_bal[s] = sat(m_bal[s] + amt);
        end else if (op == 5) begin
            if (d < 0 || d == s) st = 5;
            else if (amt > m_bal[s]) st = 4;
            else begin
                m_bal[s] -= amt;
                m_bal[d] = sat(m_bal[d] + amt);
            end
        end
        bal = m_bal[s];
    endtask

    int obs_st, obs_bal, obs_lat;

    task automatic txn(input string tag, input int op, input int card, input int pin,
                       input int amt, input int dest, input int hold);
        int e_st, e_bal, e_cr, e_lat, lat, w;
        model_txn(op, card, pin, amt, dest, e_st, e_bal, e_cr, e_lat);
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        bus.req_op     = 3'(op);
        bus.req_card   = 12'(card);
        bus.req_pin    = 8'(pin);
        bus.req_amount = 10'(amt);
        bus.req_dest   = 12'(dest);
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check_eq({tag, "_lat"}, lat, e_lat);
        check_eq({tag, "_status"}, bus.rsp_status, e_st);
        check_eq({tag, "_balance"}, bus.rsp_balance, e_bal);
        check_eq({tag, "_credit"}, bus.rsp_is_credit, e_cr);
        obs_st  = int'(bus.rsp_status);
        obs_bal = int'(bus.rsp_balance);
        obs_lat = lat;
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            check_eq({tag, "_hold_valid"}, bus.rsp_valid, 1);
            check_eq({tag, "_hold_status"}, bus.rsp_status, e_st);
            check_eq({tag, "_hold_balance"}, bus.rsp_balance, e_bal);
            check_eq({tag, "_hold_req_ready"}, bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check_eq({tag, "_rsp_drop"}, bus.rsp_valid, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, r, card, pin, amt, dest, w;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_card = '0; bus.req_pin = '0;
        bus.req_amount = '0; bus.req_dest = '0; bus.rsp_ready = 1'b0;
        do_reset();

        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_status", bus.rsp_status, 0);
        check_eq("rst_rsp_balance", bus.rsp_balance, 0);
        check_eq("rst_rsp_credit", bus.rsp_is_credit, 0);

        // 1. find card
        txn("t1_find", 0, 1281, 0, 0, 0, 0);
        check_eq("t1_lat3", obs_lat, 3);
        check_eq("t1_bal500", obs_bal, 500);

        // 2. lockout
        txn("t2_bad1", 1, 1281, 'h00, 0, 0, 0);
        check_eq("t2_bad1_code", obs_st, 2);
        txn("t2_bad2", 1, 1281, 'h00, 0, 0, 0);
        check_eq("t2_bad2_code", obs_st, 2);
        txn("t2_bad3", 1, 1281, 'h00, 0, 0, 0);
        check_eq("t2_bad3_code", obs_st, 3);
        txn("t2_good_locked", 1, 1281, 'hCD, 0, 0, 0);
        check_eq("t2_locked_code", obs_st, 3);
        do_reset();
        txn("t2_after_rst", 1, 1281, 'hCD, 0, 0, 0);
        check_eq("t2_after_rst_code", obs_st, 0);

        // 3. withdraw
        txn("t3_wd600", 3, 1281, 0, 600, 0, 0);
        check_eq("t3_wd600_code", obs_st, 4);
        txn("t3_wd200", 3, 1281, 0, 200, 0, 0);
        check_eq("t3_wd200_bal", obs_bal, 300);
        txn("t3_bal", 2, 1281, 0, 0, 0, 0);
        check_eq("t3_bal300", obs_bal, 300);

        // 4. saturating deposit, unauthenticated withdraw
        txn("t4_auth", 1, 1146, 'h46, 0, 0, 0);
        txn("t4_dep", 4, 1146, 0, 100, 0, 0);
        check_eq("t4_dep_sat", obs_bal, 65535);
        txn("t4_noauth", 3, 2133, 0, 10, 0, 0);
        check_eq("t4_noauth_code", obs_st, 7);

        // 5. wires
        do_reset();
        txn("t5_auth", 1, 1281, 'hCD, 0, 0, 0);
        txn("t5_wire", 5, 1281, 0, 100, 3698, 0);
        check_eq("t5_wire_bal", obs_bal, 400);
        check_eq("t5_wire_lat", obs_lat, 5);
        txn("t5_auth2", 1, 3698, 'hDB, 0, 0, 0);
        txn("t5_bal2", 2, 3698, 0, 0, 0, 0);
        check_eq("t5_bal1300", obs_bal, 1300);
        txn("t5_nodest", 5, 3698, 0, 10, 4000, 0);
        check_eq("t5_nodest_code", obs_st, 5);
        txn("t5_auth3", 1, 1281, 'hCD, 0, 0, 0);
        txn("t5_self", 5, 1281, 0, 10, 1281, 0);
        check_eq("t5_self_code", obs_st, 5);

        // 6. miss latency, backpressure, bad op
        txn("t6_miss", 0, 4000, 0, 0, 0, 5);
        check_eq("t6_miss_lat", obs_lat, 22);
        txn("t6_badop", 7, 1281, 0, 0, 0, 2);
        check_eq("t6_badop_lat", obs_lat, 2);

        // reset while the scan is in progress
        bus.req_op = 3'd0; bus.req_card = 12'd4000; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_eq("t6_midrst_rsp_valid", bus.rsp_valid, 0);
        check_eq("t6_midrst_req_ready", bus.req_ready, 1);
        w = 0;
        repeat (25) begin @(posedge clk); #1; if (bus.rsp_valid) w++; end
        check_eq("t6_midrst_no_rsp", w, 0);
        txn("t6_after", 0, 3698, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            r    = $urandom_range(0, 21);
            card = (r >= 20) ? 4000 : m_card[r];
            r    = $urandom_range(0, 21);
            dest = (r >= 20) ? 4000 : m_card[r];
            op   = $urandom_range(0, 9);
            if (op > 7) op = 3 + (op - 8);
            amt  = $urandom_range(0, 1023);
            pin  = ($urandom_range(0, 3) != 0 && find(card) >= 0) ? m_pin[find(card)]
                                                                   : $urandom_range(0, 255);
            if (op >= 2 && op <= 5 && $urandom_range(0, 2) != 0 && find(card) >= 0)
                txn("rnd_auth", 1, card, m_pin[find(card)], 0, 0, 0);
            txn("rnd", op, card, pin, amt, dest, $urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
